// File: rtl/mult_accumulator_if.sv
// Product-in / result-out stream bundle for the multiplier-downstream accumulator.
// The slave side is the accumulator; the master side feeds products and drains results.
interface mult_accumulator_if #(
   parameter int N     = 3,
   parameter int LEN   = 4,
   parameter int ACC_W = 2*N + $clog2(LEN),
   parameter int CNT_W = $clog2(LEN+1)
);
   logic             prod_valid;
   logic             prod_ready;
   logic [2*N-1:0]   prod;
   logic             prod_last;
   logic             acc_valid;
   logic             acc_ready;
   logic [ACC_W-1:0] acc_data;
   logic [CNT_W-1:0] acc_count;

   modport slave (
      input  prod_valid, prod, prod_last, acc_ready,
      output prod_ready, acc_valid, acc_data, acc_count
   );

   modport master (
      output prod_valid, prod, prod_last, acc_ready,
      input  prod_ready, acc_valid, acc_data, acc_count
   );
endinterface

// File: rtl/mult_accumulator.sv
// Sums 2N-bit unsigned products into dot-product results of up to LEN terms,
// closing on the LEN-th term or on prod_last, and holds each result until accepted.
module mult_accumulator #(
   parameter int N     = 3,
   parameter int LEN   = 4,
   parameter int ACC_W = 2*N + $clog2(LEN),
   parameter int CNT_W = $clog2(LEN+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_accumulator_if.slave    bus
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] sum_reg, sum_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [ACC_W-1:0] acc_data_reg, acc_data_next;
   logic [CNT_W-1:0] acc_count_reg, acc_count_next;

   logic             prod_hs;
   logic             close_term;
   logic [ACC_W-1:0] term_sum;

   // Handshake flags decode only from the state register, so nothing combinational
   // reaches an output from an input.
   assign bus.prod_ready = (state_reg == ACCUM);
   assign bus.acc_valid  = (state_reg == DONE);
   assign bus.acc_data   = acc_data_reg;
   assign bus.acc_count  = acc_count_reg;

   assign prod_hs    = bus.prod_valid && (state_reg == ACCUM);
   assign close_term = bus.prod_last || (cnt_reg == CNT_W'(LEN - 1));
   // The first term loads rather than adds, so no stale sum leaks into a new result.
   assign term_sum   = (cnt_reg == '0) ? ACC_W'(bus.prod)
                                       : sum_reg + ACC_W'(bus.prod);

   always_comb begin
      state_next     = state_reg;
      sum_next       = sum_reg;
      cnt_next       = cnt_reg;
      acc_data_next  = acc_data_reg;
      acc_count_next = acc_count_reg;
      case (state_reg)
         ACCUM: begin
            if (prod_hs) begin
               if (close_term) begin
                  acc_data_next  = term_sum;
                  acc_count_next = cnt_reg + CNT_W'(1);
                  sum_next       = '0;
                  cnt_next       = '0;
                  state_next     = DONE;
               end else begin
                  sum_next = term_sum;
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (bus.acc_ready) begin
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACCUM;
         sum_reg       <= '0;
         cnt_reg       <= '0;
         acc_data_reg  <= '0;
         acc_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         sum_reg       <= sum_next;
         cnt_reg       <= cnt_next;
         acc_data_reg  <= acc_data_next;
         acc_count_reg <= acc_count_next;
      end
   end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator (N=3, LEN=4): streams hand-computed product
// sequences and checks the result handshake cycle by cycle.
module tb_mult_accumulator;

   localparam int N     = 3;
   localparam int LEN   = 4;
   localparam int ACC_W = 2*N + $clog2(LEN);
   localparam int CNT_W = $clog2(LEN+1);

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   mult_accumulator_if #(.N(N), .LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mult_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic push(input logic [2*N-1:0] p, input logic last);
      bus.prod       = p;
      bus.prod_last  = last;
      bus.prod_valid = 1'b1;
      step();
   endtask

   task automatic idle();
      bus.prod_valid = 1'b0;
      bus.prod_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input int data, input int count);
      check({tag, ".valid"}, 32'(bus.acc_valid), 32'd1);
      check({tag, ".data"},  32'(bus.acc_data),  32'(data));
      check({tag, ".count"}, 32'(bus.acc_count), 32'(count));
      check({tag, ".pready"}, 32'(bus.prod_ready), 32'd0);
   endtask

   task automatic release_result(input string tag);
      idle();
      bus.acc_ready = 1'b1;
      step();
      check({tag, ".released"}, 32'(bus.acc_valid), 32'd0);
      check({tag, ".pready_back"}, 32'(bus.prod_ready), 32'd1);
      bus.acc_ready = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst           = 1'b1;
      bus.prod      = '0;
      bus.prod_last = 1'b0;
      bus.prod_valid = 1'b0;
      bus.acc_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst.valid",  32'(bus.acc_valid),  32'd0);
      check("rst.data",   32'(bus.acc_data),   32'd0);
      check("rst.count",  32'(bus.acc_count),  32'd0);
      check("rst.pready", 32'(bus.prod_ready), 32'd1);

      // 1: four full-scale terms back to back
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      check("t1.no_early", 32'(bus.acc_valid), 32'd0);
      push(6'd49, 1'b0);
      idle();
      check_result("t1", 196, 4);
      release_result("t1");

      // 2: early close, then one-cycle DONE with acc_ready high, then restart
      bus.acc_ready = 1'b1;
      push(6'd6, 1'b0);
      push(6'd10, 1'b1);
      check_result("t2a", 16, 2);
      bus.prod      = 6'd3;
      bus.prod_last = 1'b1;
      step();
      check("t2.done_1cyc", 32'(bus.acc_valid), 32'd0);
      step();
      check_result("t2b", 3, 1);
      release_result("t2b");

      // 3: backpressure with a product waiting
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      bus.prod      = 6'd7;
      bus.prod_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_result("t3.hold", 196, 4);
         step();
      end
      check_result("t3.hold", 196, 4);
      bus.acc_ready = 1'b1;
      step();
      check("t3.accum", 32'(bus.acc_valid), 32'd0);
      bus.acc_ready = 1'b0;
      step();
      check_result("t3b", 7, 1);
      release_result("t3b");

      // 4: gaps between terms; prod_last while idle must be ignored
      push(6'd5, 1'b0);
      idle();
      bus.prod_last = 1'b1;
      step();
      step();
      step();
      check("t4.gap_valid", 32'(bus.acc_valid), 32'd0);
      push(6'd5, 1'b0);
      idle();
      step();
      push(6'd5, 1'b0);
      check("t4.gap_valid2", 32'(bus.acc_valid), 32'd0);
      push(6'd5, 1'b0);
      idle();
      check_result("t4", 20, 4);
      release_result("t4");

      // 5: reset mid-stream discards the partial sum; rst beats prod_valid
      push(6'd49, 1'b0);
      push(6'd49, 1'b0);
      rst = 1'b1;
      push(6'd49, 1'b1);
      rst = 1'b0;
      idle();
      check("t5.rst_valid", 32'(bus.acc_valid), 32'd0);
      check("t5.rst_data",  32'(bus.acc_data),  32'd0);
      push(6'd1, 1'b0);
      push(6'd2, 1'b0);
      push(6'd3, 1'b0);
      check("t5.no_pulse", 32'(bus.acc_valid), 32'd0);
      push(6'd4, 1'b0);
      idle();
      check_result("t5", 10, 4);
      release_result("t5");

      // 6: prod_last coinciding with the LEN-th term closes once
      push(6'd1, 1'b0);
      push(6'd1, 1'b0);
      push(6'd1, 1'b0);
      push(6'd1, 1'b1);
      idle();
      check_result("t6", 4, 4);
      release_result("t6");
      step();
      check("t6.single", 32'(bus.acc_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
